mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_pkg.sv | 75 +++++++
 rtl/mem_load_ext.sv | 38 +++
 rtl/mem_lsu.sv | 166 ++++++++++++++++
 tb/tb_mem_lsu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: mem_op encodings, FSM states,
// the latched bus command, and helpers that classify ops and build a bus
// command (word address, byte enables, replicated store data).
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dbus_cmd_t;

    // Codes 9..15 are unused and behave like NONE (plain register pass-through).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op != MEM_NONE) && (op <= MEM_SW);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic r;
        r = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: r = lo[0];
            MEM_LW, MEM_SW:          r = (lo != 2'b00);
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte enables only ever use the address bits that matter for the access
    // size, so a misaligned address is naturally truncated to its alignment.
    function automatic dbus_cmd_t build_cmd(input logic [3:0]  op,
                                            input logic [31:0] addr,
                                            input logic [31:0] sdata);
        dbus_cmd_t c;
        c.we   = is_store_op(op);
        c.addr = {addr[31:2], 2'b00};
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                c.be    = 4'b0001 << addr[1:0];
                c.wdata = {4{sdata[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                c.be    = 4'b0011 << {addr[1], 1'b0};
                c.wdata = {2{sdata[15:0]}};
            end
            default: begin
                c.be    = 4'hF;
                c.wdata = sdata;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Purpose: pick the addressed byte/half out of a bus read word and extend it.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever its inputs are.
// Ports: rdata (bus word), addr_lo (byte offset), op (mem_op) -> result (32-bit).
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // addr_lo[0] is ignored for halves: misaligned halves read the aligned one.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (op)
            MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: result = {24'd0, byte_sel};
            MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Purpose: memory stage; passes ALU results to write-back, runs one bus access per load/store.
// Latency: non-memory ops 1 edge; loads/stores >= 2 edges (request edge, ack edge), unbounded ack wait.
// Backpressure: stall_req holds upstream while an access is starting or waiting for dbus_ack.
// Ports: mem_* (stage inputs), wb_* (registered write-back), dbus_* (data bus), stall_req, misalign_o.
// Build option MEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW skip the bus and pulse misalign_o;
// without it misaligned accesses are truncated to natural alignment and misalign_o is tied low.
module mem_lsu
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stall_req,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        misalign_o
);

    lsu_state_e  state_q, state_d;
    logic        dbus_req_q, dbus_req_d;
    dbus_cmd_t   cmd_q, cmd_d;

    // Load context captured at the request edge, consumed at the ack edge.
    logic [3:0]  ld_op_q, ld_op_d;
    logic [1:0]  ld_lo_q, ld_lo_d;
    logic [4:0]  ld_wd_q, ld_wd_d;
    logic        ld_wreg_q, ld_wreg_d;

    logic [4:0]  wb_wd_q, wb_wd_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;

    logic        is_mem;
    logic        trap;
    logic        start;
    logic [31:0] ld_result;

    assign is_mem = is_mem_op(mem_op);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trap       = is_mem && is_misaligned(mem_op, mem_addr[1:0]);
    assign misalign_d = (state_q == ST_IDLE) && trap;
    assign misalign_o = misalign_q;
`else
    assign trap       = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign start = is_mem && !trap;

    // Gated by rst_n so the stall drops the instant reset asserts, even while
    // a memory op is still presented on the inputs.
    assign stall_req = rst_n && (((state_q == ST_IDLE) && start) ||
                                 ((state_q == ST_BUS)  && !dbus_ack));

    mem_load_ext u_load_ext (
        .rdata   (dbus_rdata),
        .addr_lo (ld_lo_q),
        .op      (ld_op_q),
        .result  (ld_result)
    );

    always_comb begin
        state_d    = state_q;
        dbus_req_d = dbus_req_q;
        cmd_d      = cmd_q;
        ld_op_d    = ld_op_q;
        ld_lo_d    = ld_lo_q;
        ld_wd_d    = ld_wd_q;
        ld_wreg_d  = ld_wreg_q;
        wb_wd_d    = wb_wd_q;
        wb_wdata_d = wb_wdata_q;
        // Every edge that is not a completed register write is a bubble.
        wb_wreg_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // dbus_ack is deliberately not looked at here.
                if (start) begin
                    state_d    = ST_BUS;
                    dbus_req_d = 1'b1;
                    cmd_d      = build_cmd(mem_op, mem_addr, mem_sdata);
                    ld_op_d    = mem_op;
                    ld_lo_d    = mem_addr[1:0];
                    ld_wd_d    = mem_wd;
                    ld_wreg_d  = mem_wreg;
                end else if (!is_mem) begin
                    wb_wd_d    = mem_wd;
                    wb_wreg_d  = mem_wreg;
                    wb_wdata_d = mem_wdata;
                end
            end
            ST_BUS: begin
                if (dbus_ack) begin
                    state_d    = ST_IDLE;
                    dbus_req_d = 1'b0;
                    if (!cmd_q.we) begin
                        wb_wd_d    = ld_wd_q;
                        wb_wreg_d  = ld_wreg_q;
                        wb_wdata_d = ld_result;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                dbus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dbus_req_q <= 1'b0;
            cmd_q      <= '0;
            ld_op_q    <= 4'd0;
            ld_lo_q    <= 2'd0;
            ld_wd_q    <= 5'd0;
            ld_wreg_q  <= 1'b0;
            wb_wd_q    <= 5'd0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dbus_req_q <= dbus_req_d;
            cmd_q      <= cmd_d;
            ld_op_q    <= ld_op_d;
            ld_lo_q    <= ld_lo_d;
            ld_wd_q    <= ld_wd_d;
            ld_wreg_q  <= ld_wreg_d;
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = cmd_q.we;
    assign dbus_addr  = cmd_q.addr;
    assign dbus_be    = cmd_q.be;
    assign dbus_wdata = cmd_q.wdata;
    assign wb_wd      = wb_wd_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_wdata   = wb_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level model sets the expected
// per-cycle outputs, one negedge process compares them, and literal checks
// pin the headline cases.
module tb_mem_lsu;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                           OP_SW = 4'd8;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst_n;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_addr, mem_sdata;
    logic [3:0]  mem_op;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stall_req, dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack, misalign_o;

    mem_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_sdata  (mem_sdata),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .stall_req  (stall_req),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_be    (dbus_be),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack),
        .misalign_o (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        int sh;
        v = rdata;
        if (op == OP_LB || op == OP_LBU) begin
            sh = int'(addr % 4) * 8;
            v  = (rdata >> sh) & 32'hFF;
            if (op == OP_LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (op == OP_LH || op == OP_LHU) begin
            sh = ((addr & 32'd2) != 0) ? 16 : 0;
            v  = (rdata >> sh) & 32'hFFFF;
            if (op == OP_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] addr);
        int b;
        if (op == OP_SB)      b = 1 << (addr % 4);
        else if (op == OP_SH) b = 3 << (addr & 32'd2);
        else                  b = 15;
        return b[3:0];
    endfunction

    function automatic logic [31:0] model_sdata(input logic [3:0] op, input logic [31:0] s);
        if (op == OP_SB) return (s & 32'hFF) * 32'h0101_0101;
        if (op == OP_SH) return (s & 32'hFFFF) * 32'h0001_0001;
        return s;
    endfunction

    // Expected outputs for the current cycle.
    logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_wreg = 0, exp_mis = 0;
    logic [31:0] exp_addr = 0, exp_sd = 0, exp_wdata = 0;
    logic [3:0]  exp_be = 0;
    logic [4:0]  exp_wd = 0;

    // Observation counters and last bus command seen.
    int          stall_cnt = 0, req_cnt = 0, mis_cnt = 0;
    logic [31:0] last_addr = 0, last_wd = 0;
    logic [3:0]  last_be = 0;
    logic        last_we = 0;

    always @(negedge clk) begin
        chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        chk("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
        if (exp_req) begin
            chk("dbus_addr", dbus_addr, exp_addr);
            chk("dbus_we", {31'd0, dbus_we}, {31'd0, exp_we});
            if (exp_we) begin
                chk("dbus_be", {28'd0, dbus_be}, {28'd0, exp_be});
                chk("dbus_wdata", dbus_wdata, exp_sd);
            end
        end
        chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, exp_wreg});
        if (exp_wreg) begin
            chk("wb_wd", {27'd0, wb_wd}, {27'd0, exp_wd});
            chk("wb_wdata", wb_wdata, exp_wdata);
        end
        chk("misalign_o", {31'd0, misalign_o}, {31'd0, exp_mis});
        stall_cnt += int'(stall_req);
        req_cnt   += int'(dbus_req);
        mis_cnt   += int'(misalign_o);
        if (dbus_req) begin
            last_addr = dbus_addr;
            last_be   = dbus_be;
            last_wd   = dbus_wdata;
            last_we   = dbus_we;
        end
    end

    // One instruction presented at posedge+1; returns at posedge+1 after it retires.
    task automatic do_instr(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay, input logic spur_ack);
        bit is_mem, is_st, mis, trapped;
        is_mem  = (op >= OP_LB) && (op <= OP_SW);
        is_st   = (op >= OP_SB) && (op <= OP_SW);
        mis     = ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]) ||
                  ((op == OP_LW || op == OP_SW) && (addr % 4 != 0));
        trapped = TRAP && is_mem && mis;
        mem_op = op; mem_addr = addr; mem_sdata = sdata;
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        dbus_ack = spur_ack; dbus_rdata = rdata;
        if (!is_mem || trapped) begin
            exp_stall = 1'b0;
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            exp_req  = 1'b0;
            exp_mis  = trapped;
            exp_wreg = is_mem ? 1'b0 : wreg;
            if (!is_mem) begin
                exp_wd    = wd;
                exp_wdata = wdata;
            end
        end else begin
            exp_stall = 1'b1;
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            exp_req  = 1'b1;
            exp_we   = is_st;
            exp_addr = addr & ~32'd3;
            exp_be   = model_be(op, addr);
            exp_sd   = model_sdata(op, sdata);
            exp_wreg = 1'b0;
            exp_mis  = 1'b0;
            for (int i = 0; i < delay; i++) begin
                dbus_rdata = $urandom;
                @(posedge clk); #1;
            end
            dbus_ack   = 1'b1;
            dbus_rdata = rdata;
            exp_stall  = 1'b0;
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            exp_req  = 1'b0;
            if (is_st) exp_wreg = 1'b0;
            else begin
                exp_wreg  = wreg;
                exp_wd    = wd;
                exp_wdata = model_load(op, addr, rdata);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t want < 100000", $time);
        $fatal(1);
    end

    int s0, r0, m0;

    initial begin
        rst_n = 1'b0;
        mem_op = OP_NONE; mem_addr = 0; mem_sdata = 0;
        mem_wd = 0; mem_wreg = 0; mem_wdata = 0;
        dbus_ack = 0; dbus_rdata = 0;
        #3;
        chk("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        chk("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Model pins.
        chk("model_lb", model_load(OP_LB, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
        chk("model_sh_be", {28'd0, model_be(OP_SH, 32'h202)}, 32'h0000_000C);

        // Pass-through, no stall.
        s0 = stall_cnt;
        do_instr(OP_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 1'b0);
        chk("none_wb_wd", {27'd0, wb_wd}, 32'd5);
        chk("none_wb_wdata", wb_wdata, 32'h1234);
        do_instr(OP_NONE, 32'h0, 32'h0, 5'd9, 1'b0, 32'h5555, 32'h0, 0, 1'b1); // spurious ack in IDLE
        chk("none_stall_cycles", s0 == stall_cnt ? 32'd0 : 32'd1, 32'd0);

        // LW with three waiting BUS cycles.
        s0 = stall_cnt;
        do_instr(OP_LW, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
        chk("lw_stall_cycles", stall_cnt - s0, 32'd4);
        chk("lw_wb_wdata", wb_wdata, 32'hDEAD_BEEF);

        do_instr(OP_LB, 32'h103, 32'h0, 5'd3, 1'b1, 32'h0, 32'h80FF_0000, 0, 1'b0);
        chk("lb_wb_wdata", wb_wdata, 32'hFFFF_FF80);
        do_instr(OP_LBU, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0, 32'h80FF_0000, 1, 1'b0);
        chk("lbu_wb_wdata", wb_wdata, 32'h0000_0080);

        do_instr(OP_SH, 32'h202, 32'h0000_ABCD, 5'd1, 1'b1, 32'h0, 32'h0, 1, 1'b0);
        chk("sh_addr", last_addr, 32'h200);
        chk("sh_be", {28'd0, last_be}, 32'hC);
        chk("sh_wdata", last_wd, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, last_we}, 32'd1);
        chk("sh_wb_wreg", {31'd0, wb_wreg}, 32'd0);

        do_instr(OP_SB, 32'h101, 32'h1234_565A, 5'd2, 1'b1, 32'h0, 32'h0, 0, 1'b0);
        chk("sb_be", {28'd0, last_be}, 32'h2);
        do_instr(OP_SW, 32'h300, 32'h1122_3344, 5'd2, 1'b1, 32'h0, 32'h0, 2, 1'b0);
        do_instr(OP_LH, 32'h102, 32'h0, 5'd10, 1'b1, 32'h0, 32'h8001_7FFF, 0, 1'b1);
        chk("lh_wb_wdata", wb_wdata, 32'hFFFF_8001);
        do_instr(OP_LHU, 32'h100, 32'h0, 5'd11, 1'b1, 32'h0, 32'h8001_7FFF, 2, 1'b0);
        chk("lhu_wb_wdata", wb_wdata, 32'h0000_7FFF);
        do_instr(OP_NONE, 32'h0, 32'h0, 5'd12, 1'b1, 32'hA5A5_0000, 32'h0, 0, 1'b0);

        // Misaligned word load.
        r0 = req_cnt; m0 = mis_cnt;
        do_instr(OP_LW, 32'h101, 32'h0, 5'd13, 1'b1, 32'h0, 32'h0102_0304, 1, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        do_instr(OP_NONE, 32'h0, 32'h0, 5'd14, 1'b1, 32'h77, 32'h0, 0, 1'b0);
        chk("mis_req_cycles", req_cnt - r0, 32'd0);
        chk("mis_pulse_cycles", mis_cnt - m0, 32'd1);
`else
        chk("mis_trunc_addr", last_addr, 32'h100);
        chk("mis_trunc_wdata", wb_wdata, 32'h0102_0304);
`endif
        do_instr(OP_LH, 32'h103, 32'h0, 5'd15, 1'b1, 32'h0, 32'hC3C3_1111, 1, 1'b0);

        // Reset in the middle of a BUS access.
        mem_op = OP_LW; mem_addr = 32'h300; mem_wd = 5'd6; mem_wreg = 1'b1;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_wreg = 1'b0; exp_mis = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_wreg = 0; exp_mis = 0;
        exp_addr = 0; exp_wd = 0; exp_wdata = 0;
        mem_op = OP_NONE; mem_addr = 0; mem_wd = 0; mem_wreg = 0; mem_wdata = 0;
        #1;
        chk("rstbus_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("rstbus_stall", {31'd0, stall_req}, 32'd0);
        chk("rstbus_dbus_addr", dbus_addr, 32'd0);
        chk("rstbus_wb_wdata", wb_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_instr(OP_LW, 32'h400, 32'h0, 5'd8, 1'b1, 32'h0, 32'hCAFE_F00D, 2, 1'b0);
        chk("post_rst_lw", wb_wdata, 32'hCAFE_F00D);
        do_instr(OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
